// File: rtl/stl_packet_engine.sv
// Byte<->packet engine between the UART byte stream and the STL request/response bridges.
// RX: collects PACKET_BYTES bytes, steers the packet to one channel, resyncs on idle timeout.
// TX: buffers RESP_DEPTH response packets and serializes them back as bytes.
module stl_packet_engine #(
    parameter int unsigned PACKET_BYTES   = 16,
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned CH_BIT_LSB     = 0,
    parameter int unsigned RESP_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      data_valid,
    output logic                      data_ready,
    input  logic [7:0]                data_in,
    output logic                      response_valid,
    input  logic                      response_ready,
    output logic [7:0]                response_data,
    output logic [NUM_CH-1:0]         pkt_valid,
    input  logic [NUM_CH-1:0]         pkt_ready,
    output logic [8*PACKET_BYTES-1:0] pkt_data,
    input  logic                      rsp_pkt_valid,
    output logic                      rsp_pkt_ready,
    input  logic [8*PACKET_BYTES-1:0] rsp_pkt_data,
    output logic                      timeout_pulse,
    output logic [CNT_W-1:0]          drop_count,
    output logic [1:0]                debug_state
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PKT_W = 8 * PACKET_BYTES;
    localparam int unsigned BC_W  = $clog2(PACKET_BYTES);
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(RESP_DEPTH + 1);

    typedef enum logic {COLLECT, DISPATCH} rx_state_t;

    rx_state_t          state_q, state_d;
    logic [BC_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [PKT_W-1:0]   pkt_d;
    logic [TO_W-1:0]    idle_q, idle_d;
    logic [CH_W-1:0]    ch_q, ch_d, ch_sel;
    logic [NUM_CH-1:0]  pkt_valid_d;
    logic               data_ready_d, timeout_d, drop_inc, accept;
    logic [CNT_W-1:0]   drop_count_d;

    // RX next-state: byte assembly, channel steering, idle timeout and drop accounting
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        pkt_d        = pkt_data;
        idle_d       = '0;
        ch_d         = ch_q;
        ch_sel       = '0;
        timeout_d    = 1'b0;
        drop_inc     = 1'b0;
        accept       = data_valid && data_ready && (state_q == COLLECT);
        pkt_valid_d  = '0;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    for (int unsigned k = 0; k < PACKET_BYTES; k++) begin
                        if (byte_cnt_q == BC_W'(k)) pkt_d[8*k +: 8] = data_in;
                    end
                    ch_sel = pkt_d[CH_BIT_LSB +: CH_W];
                    if (byte_cnt_q == BC_W'(PACKET_BYTES - 1)) begin
                        byte_cnt_d = '0;
                        if (32'(ch_sel) < NUM_CH) begin
                            state_d = DISPATCH;
                            ch_d    = ch_sel;
                        end else begin
                            drop_inc = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (byte_cnt_q != '0)) begin
                    if (idle_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        byte_cnt_d = '0;
                        timeout_d  = 1'b1;
                        drop_inc   = 1'b1;
                    end else begin
                        idle_d = idle_q + TO_W'(1);
                    end
                end
            end
            DISPATCH: begin
                if (|(pkt_valid & pkt_ready)) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
        if (state_d == DISPATCH) begin
            for (int unsigned k = 0; k < NUM_CH; k++) pkt_valid_d[k] = (ch_d == CH_W'(k));
        end
        data_ready_d = (state_d == COLLECT);
        drop_count_d = (drop_inc && (drop_count != '1)) ? drop_count + CNT_W'(1) : drop_count;
    end

    // RX state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= COLLECT;
            byte_cnt_q    <= '0;
            pkt_data      <= '0;
            idle_q        <= '0;
            ch_q          <= '0;
            pkt_valid     <= '0;
            data_ready    <= 1'b0;
            timeout_pulse <= 1'b0;
            drop_count    <= '0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            pkt_data      <= pkt_d;
            idle_q        <= idle_d;
            ch_q          <= ch_d;
            pkt_valid     <= pkt_valid_d;
            data_ready    <= data_ready_d;
            timeout_pulse <= timeout_d;
            drop_count    <= drop_count_d;
        end
    end

    logic [PKT_W-1:0] mem [RESP_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [BC_W-1:0]  tx_idx_q, tx_idx_d;
    logic             push, pop, byte_hs;
    logic [PKT_W-1:0] head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // TX next-state: FIFO occupancy/pointers and byte index; head held until its last byte
    always_comb begin
        push     = rsp_pkt_valid && rsp_pkt_ready;
        byte_hs  = response_valid && response_ready;
        pop      = byte_hs && (tx_idx_q == BC_W'(PACKET_BYTES - 1));
        tx_idx_d = tx_idx_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (byte_hs) tx_idx_d = pop ? '0 : tx_idx_q + BC_W'(1);
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push && !pop)      occ_d = occ_q + OCC_W'(1);
        else if (pop && !push) occ_d = occ_q - OCC_W'(1);
    end

    // TX control registers; valid/ready reflect the occupancy after this cycle's push/pop
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            occ_q          <= '0;
            tx_idx_q       <= '0;
            response_valid <= 1'b0;
            rsp_pkt_ready  <= 1'b0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            occ_q          <= occ_d;
            tx_idx_q       <= tx_idx_d;
            response_valid <= (occ_d != '0);
            rsp_pkt_ready  <= (occ_d != OCC_W'(RESP_DEPTH));
        end
    end

    // Response packet storage
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= rsp_pkt_data;
    end

    assign head = mem[rd_ptr_q];

    // Serializer byte select, forced to zero while nothing is queued
    always_comb begin
        response_data = '0;
        for (int unsigned k = 0; k < PACKET_BYTES; k++) begin
            if (response_valid && (tx_idx_q == BC_W'(k))) response_data = head[8*k +: 8];
        end
    end

    assign debug_state = {response_valid, state_q == DISPATCH};

endmodule

// File: tb/tb_stl_packet_engine.sv
// Directed bench for stl_packet_engine: RX table vectors plus hand sequences for
// backpressure, timeout, response FIFO, invalid channel and mid-operation reset.
module tb_stl_packet_engine;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // two-channel instance, timeout 50
    logic         dv2, dr2, rv2, rr2, rpv2, rpr2, tp2;
    logic [7:0]   din2, rd2, dc2;
    logic [1:0]   pv2, pr2, ds2;
    logic [127:0] pd2, rpd2;
    // three-channel instance, timeout disabled
    logic         dv3, dr3, rv3, rr3, rpv3, rpr3, tp3;
    logic [7:0]   din3, rd3, dc3;
    logic [2:0]   pv3, pr3;
    logic [1:0]   ds3;
    logic [127:0] pd3, rpd3;

    stl_packet_engine #(.PACKET_BYTES(16), .NUM_CH(2), .CH_BIT_LSB(0), .RESP_DEPTH(4),
                        .TIMEOUT_CYCLES(50), .CNT_W(8)) dut2 (
        .clk(clk), .reset(reset), .data_valid(dv2), .data_ready(dr2), .data_in(din2),
        .response_valid(rv2), .response_ready(rr2), .response_data(rd2),
        .pkt_valid(pv2), .pkt_ready(pr2), .pkt_data(pd2),
        .rsp_pkt_valid(rpv2), .rsp_pkt_ready(rpr2), .rsp_pkt_data(rpd2),
        .timeout_pulse(tp2), .drop_count(dc2), .debug_state(ds2));

    stl_packet_engine #(.PACKET_BYTES(16), .NUM_CH(3), .CH_BIT_LSB(0), .RESP_DEPTH(4),
                        .TIMEOUT_CYCLES(0), .CNT_W(8)) dut3 (
        .clk(clk), .reset(reset), .data_valid(dv3), .data_ready(dr3), .data_in(din3),
        .response_valid(rv3), .response_ready(rr3), .response_data(rd3),
        .pkt_valid(pv3), .pkt_ready(pr3), .pkt_data(pd3),
        .rsp_pkt_valid(rpv3), .rsp_pkt_ready(rpr3), .rsp_pkt_data(rpd3),
        .timeout_pulse(tp3), .drop_count(dc3), .debug_state(ds3));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] make_req(input logic [7:0] b0, input logic [7:0] base);
        logic [127:0] p;
        p[7:0] = b0;
        for (int k = 1; k < 16; k++) p[8*k +: 8] = base + 8'(k);
        return p;
    endfunction

    function automatic logic [7:0] tx_byte(input int i, input int k);
        return 8'((i + 1) * 16 + k);
    endfunction

    function automatic logic [127:0] tx_pkt(input int i);
        logic [127:0] p;
        for (int k = 0; k < 16; k++) p[8*k +: 8] = tx_byte(i, k);
        return p;
    endfunction

    // one byte through the request handshake; called at posedge+1
    task automatic send_byte(input int which, input logic [7:0] b);
        int n = 0;
        if (which == 2) begin
            dv2 = 1'b1; din2 = b;
            while (!dr2 && n < 100) begin @(posedge clk); #1; n++; end
        end else begin
            dv3 = 1'b1; din3 = b;
            while (!dr3 && n < 100) begin @(posedge clk); #1; n++; end
        end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL send_byte data_ready never rose (dut%0d)", which);
        end
        @(posedge clk); #1;
        dv2 = 1'b0; dv3 = 1'b0;
    endtask

    task automatic send_bytes(input int which, input logic [127:0] p, input int from);
        for (int k = from; k < 16; k++) send_byte(which, p[8*k +: 8]);
    endtask

    task automatic push_rsp(input logic [127:0] p);
        int n = 0;
        rpd2 = p; rpv2 = 1'b1;
        while (!rpr2 && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL push_rsp rsp_pkt_ready never rose");
        end
        @(posedge clk); #1;
        rpv2 = 1'b0;
    endtask

    typedef struct {
        logic [7:0] b0;
        logic [7:0] base;
        logic [1:0] exp_pv;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
    } rx_vec_t;

    rx_vec_t tbl[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] p;
        logic ok, ok2;
        int first, npulse, idx, cyc;
        logic hs, push;

        tbl[0] = '{8'h01, 8'h00, 2'b10, 8'h01, 8'h0F};
        tbl[1] = '{8'h00, 8'h10, 2'b01, 8'h00, 8'h1F};
        tbl[2] = '{8'hFE, 8'h80, 2'b01, 8'hFE, 8'h8F};
        tbl[3] = '{8'h33, 8'hA0, 2'b10, 8'h33, 8'hAF};

        reset = 1'b1;
        dv2 = 0; din2 = 0; rr2 = 0; pr2 = 0; rpv2 = 0; rpd2 = '0;
        dv3 = 0; din3 = 0; rr3 = 0; pr3 = 0; rpv3 = 0; rpd3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {dr2, rv2, rd2, pv2, rpr2, tp2, dc2, ds2}, '0);
        chk("reset_pkt_data", pd2, '0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_data_ready", dr2, 1'b1);
        chk("post_reset_rsp_ready", rpr2, 1'b1);
        chk("post_reset_resp_valid", rv2, 1'b0);

        // request packets from the table
        for (int i = 0; i < 4; i++) begin
            p = make_req(tbl[i].b0, tbl[i].base);
            send_bytes(2, p, 0);
            chk("tbl_pkt_valid", pv2, tbl[i].exp_pv);
            chk("tbl_pkt_data", pd2, p);
            chk("tbl_first_byte", pd2[7:0], tbl[i].exp_first);
            chk("tbl_last_byte", pd2[127:120], tbl[i].exp_last);
            chk("tbl_data_ready_low", dr2, 1'b0);
            chk("tbl_debug_state", ds2, 2'b01);
            pr2 = tbl[i].exp_pv;
            @(posedge clk); #1;
            pr2 = '0;
            chk("tbl_pkt_valid_clear", pv2, 2'b00);
            chk("tbl_data_ready_back", dr2, 1'b1);
        end

        // backpressure: 20 cycles stalled, wrong-channel ready ignored
        p = make_req(8'h01, 8'h00);
        send_bytes(2, p, 0);
        dv2 = 1'b1; din2 = 8'hEE;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pr2 = (i % 3 == 0) ? 2'b01 : 2'b00;
            @(posedge clk); #1;
            if (pv2 !== 2'b10 || pd2 !== p || dr2 !== 1'b0) ok = 1'b0;
        end
        chk("hold_stable", ok, 1'b1);
        pr2 = 2'b10;
        @(posedge clk); #1;
        pr2 = '0; dv2 = 1'b0;
        chk("hold_release_ready", dr2, 1'b1);
        chk("hold_release_valid", pv2, 2'b00);

        // timeout: 5 bytes then idle; pulse on the 50th idle edge
        for (int k = 0; k < 5; k++) send_byte(2, 8'(8'h11 + k));
        first = 0; npulse = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (tp2) begin
                if (first == 0) first = k;
                npulse++;
            end
        end
        chk("timeout_cycle", 32'(first), 32'd50);
        chk("timeout_pulses", 32'(npulse), 32'd1);
        chk("timeout_drop_count", dc2, 8'd1);
        p = make_req(8'h00, 8'h20);
        send_bytes(2, p, 0);
        chk("after_timeout_valid", pv2, 2'b01);
        chk("after_timeout_data", pd2, p);
        pr2 = 2'b01; @(posedge clk); #1; pr2 = '0;

        // byte arriving on the last idle cycle wins over the timeout
        p = make_req(8'h41, 8'h41);
        send_byte(2, p[7:0]);
        npulse = 0;
        repeat (49) begin @(posedge clk); #1; if (tp2) npulse++; end
        send_byte(2, p[15:8]);
        if (tp2) npulse++;
        repeat (3) begin @(posedge clk); #1; if (tp2) npulse++; end
        chk("edge_no_timeout", 32'(npulse), 32'd0);
        chk("edge_drop_count", dc2, 8'd1);
        send_bytes(2, p, 2);
        chk("edge_pkt_valid", pv2, 2'b10);
        chk("edge_pkt_data", pd2, p);
        pr2 = 2'b10; @(posedge clk); #1; pr2 = '0;

        // response FIFO: fill, hold, then drain with a blocked fifth push
        rr2 = 1'b0;
        chk("tx_idle_valid", rv2, 1'b0);
        push_rsp(tx_pkt(0));
        chk("tx_first_valid", rv2, 1'b1);
        chk("tx_first_byte", rd2, tx_byte(0, 0));
        chk("tx_debug_busy", ds2[1], 1'b1);
        for (int i = 1; i < 4; i++) push_rsp(tx_pkt(i));
        chk("tx_full_ready", rpr2, 1'b0);
        rpd2 = tx_pkt(4); rpv2 = 1'b1;
        ok = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (rpr2 !== 1'b0 || rd2 !== tx_byte(0, 0) || rv2 !== 1'b1) ok = 1'b0;
        end
        chk("tx_full_hold", ok, 1'b1);
        idx = 0; cyc = 0; ok = 1'b1; ok2 = 1'b1;
        while (idx < 80 && cyc < 500) begin
            rr2 = cyc[0];
            hs = rv2 && rr2;
            push = rpv2 && rpr2;
            if (hs) chk("tx_byte", rd2, tx_byte(idx / 16, idx % 16));
            @(posedge clk); #1;
            cyc++;
            if (push) rpv2 = 1'b0;
            if (hs) begin
                idx++;
                if (idx == 16) chk("tx_ready_after_pop", rpr2, 1'b1);
                else if (idx < 16 && rpr2 !== 1'b0) ok = 1'b0;
                if (idx < 80 && rv2 !== 1'b1) ok2 = 1'b0;
            end
        end
        rr2 = 1'b0;
        chk("tx_ready_low_while_full", ok, 1'b1);
        chk("tx_no_bubble", ok2, 1'b1);
        chk("tx_byte_total", 32'(idx), 32'd80);
        chk("tx_drained_valid", rv2, 1'b0);
        chk("tx_drained_ready", rpr2, 1'b1);

        // three channels: channel 3 dropped, channel 2 delivered
        p = make_req(8'h03, 8'h60);
        send_bytes(3, p, 0);
        chk("ch3_no_valid", pv3, 3'b000);
        chk("ch3_drop_count", dc3, 8'd1);
        chk("ch3_data_ready", dr3, 1'b1);
        chk("ch3_debug", ds3, 2'b00);
        p = make_req(8'h02, 8'h70);
        send_bytes(3, p, 0);
        chk("ch2_valid", pv3, 3'b100);
        chk("ch2_data", pd3, p);
        pr3 = 3'b001; @(posedge clk); #1;
        chk("ch2_wrong_ready_ignored", pv3, 3'b100);
        pr3 = 3'b100; @(posedge clk); #1; pr3 = '0;
        chk("ch2_released", pv3, 3'b000);
        p = make_req(8'h07, 8'h90);
        send_bytes(3, p, 0);
        chk("ch3_drop_count_2", dc3, 8'd2);

        // reset mid-operation
        for (int k = 0; k < 7; k++) send_byte(2, 8'(8'hB0 + k));
        push_rsp(tx_pkt(5));
        push_rsp(tx_pkt(6));
        chk("pre_reset_resp_valid", rv2, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_reset_outputs", {dr2, rv2, rd2, pv2, rpr2, tp2, dc2, ds2}, '0);
        chk("mid_reset_dut3_drop", dc3, 8'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("after_reset_resp_valid", rv2, 1'b0);
        chk("after_reset_drop", dc2, 8'd0);
        chk("after_reset_ready", dr2, 1'b1);
        p = make_req(8'h01, 8'hC0);
        send_bytes(2, p, 0);
        chk("after_reset_pkt_valid", pv2, 2'b10);
        chk("after_reset_pkt_data", pd2, p);
        pr2 = 2'b10; @(posedge clk); #1; pr2 = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
